match_controller: RTL and testbench
===================================

MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 7, points needed to win, legal range 1..15.
REQ-002 SHALL have parameter SERVE_FRAMES, default 120, frames held before a serve or after game over, legal range 1..255.
REQ-003 SHALL have port clk50M  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port endofframe  input  1  one-clk50M-cycle pulse per video frame.
REQ-006 SHALL have port missed  input  2  level from ball movement; bit0 = left wall hit, bit1 = right wall hit.
REQ-007 SHALL have port is_moving  input  1  level, high while either joystick is deflected.
REQ-008 SHALL have port restart  output  1  high holds the ball at centre; low lets it move.
REQ-009 SHALL have port score_one  output  4  player-one score, binary.
REQ-010 SHALL have port score_two  output  4  player-two score, binary.
REQ-011 SHALL have port point_pulse  output  2  one-cycle pulse; bit0 = player one scored, bit1 = player two scored.
REQ-012 SHALL have port winner  output  2  00 none, 01 player one, 10 player two, 11 tie.
REQ-013 SHALL have port game_state  output  2  current FSM state encoding.

Function
REQ-014 SHALL implement states IDLE=00, SERVE=01, PLAY=10, OVER=11, registered on clk50M.
REQ-015 SHALL drive restart high in IDLE, SERVE and OVER, and low only in PLAY, decoded from the state register with no added latency.
REQ-016 SHALL, in IDLE with is_moving high, clear both scores and winner, load the frame timer with SERVE_FRAMES, and enter SERVE on the next edge.
REQ-017 SHALL decrement the frame timer only on cycles with endofframe high, saturating at 0.
REQ-018 SHALL, in SERVE, enter PLAY when timer==0 and is_moving is high, subject to REQ-027.
REQ-019 SHALL, in PLAY, act on missed only in a cycle with endofframe high and missed!=00, and ignore missed in every other state and cycle.
REQ-020 SHALL, on a qualifying miss, increment score_two for missed[0] and score_one for missed[1]; missed=11 increments both in the same cycle.
REQ-021 SHALL assert point_pulse for exactly one cycle, coincident with the registered score update.
REQ-022 SHALL, after a scoring update, enter OVER if either score equals WIN_SCORE, otherwise enter SERVE; in both cases the timer reloads with SERVE_FRAMES.
REQ-023 SHALL set winner to 01, 10, or 11 (both reached WIN_SCORE in the same update) on entry to OVER.
REQ-024 SHALL saturate each score at WIN_SCORE and never wrap.
REQ-025 SHALL, in OVER, return to IDLE when timer==0, holding scores and winner until the next IDLE->SERVE transition.
REQ-026 SHALL count a miss at most once per serve: leaving PLAY immediately blocks repeated counts while missed stays high.

Configuration
REQ-027 SHALL, with macro MATCH_AUTO_SERVE_EN defined, leave SERVE when timer==0 regardless of is_moving; without it, SERVE SHALL wait at timer==0 until is_moving is high.

Reset
REQ-028 SHALL, on reset high, immediately force state=IDLE, restart=1, both scores=0, point_pulse=00, winner=00, timer=0, including mid-PLAY and mid-timer.
REQ-029 SHALL resume normal operation on the first clk50M rising edge after reset deasserts.

Structure
REQ-030 SHALL take the state encoding localparams, score width (4) and timer width (8) from shared package pong_pkg.
REQ-031 SHALL place the loadable, endofframe-decrementing timer in sub-module frame_timer (ports: clk50M, reset, load, load_value, tick, count, done).

Verification
REQ-032 Reset, then is_moving=1 -> one cycle later game_state=01, restart=1, scores=0; after 120 endofframe pulses with is_moving=1 -> game_state=10, restart=0.
REQ-033 In PLAY, endofframe with missed=01 -> score_two 0->1, point_pulse=10 for one cycle, game_state=01; missed held at 01 for 5 more frames -> score_two stays 1.
REQ-034 WIN_SCORE=3, score_one=2, endofframe with missed=10 -> score_one=3, winner=01, game_state=11; after 120 frames -> game_state=00, score_one still 3.
REQ-035 Both scores at 2 with WIN_SCORE=3, endofframe with missed=11 -> both scores=3, point_pulse=11, winner=11, game_state=11.
REQ-036 Reset asserted mid-PLAY with score_one=4 -> same cycle game_state=00, restart=1, score_one=0.
REQ-037 SERVE at timer==0 with is_moving=0 -> stays in SERVE without MATCH_AUTO_SERVE_EN; enters PLAY on the next edge with the macro defined.

Source files
------------

// File: rtl/pong_pkg.sv
// pong_pkg: shared constants and types for the pong match controller.
//   SCORE_W / TIMER_W  : score and frame-timer widths
//   ST_*               : game-state encodings (also exported on game_state)
//   WIN_*              : winner encodings
//   sat_inc()          : score increment that stops at a limit
package pong_pkg;

  localparam int unsigned SCORE_W = 4;
  localparam int unsigned TIMER_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SERVE = 2'b01;
  localparam logic [1:0] ST_PLAY  = 2'b10;
  localparam logic [1:0] ST_OVER  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SERVE = ST_SERVE,
    PLAY  = ST_PLAY,
    OVER  = ST_OVER
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_ONE  = 2'b01;
  localparam logic [1:0] WIN_TWO  = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  // Increment s when hit is set, but never past lim.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s,
                                                 input logic               hit,
                                                 input logic [SCORE_W-1:0] lim);
    return (hit && (s < lim)) ? s + SCORE_W'(1) : s;
  endfunction

endpackage

// File: rtl/match_controller_if.sv
// match_controller_if: game-level signals between the match controller and
// the rest of the pong design.
//   endofframe  : one-cycle pulse per video frame (to controller)
//   missed[1:0] : wall-hit levels, bit0 left, bit1 right (to controller)
//   is_moving   : joystick deflected level (to controller)
//   restart     : hold ball at centre (from controller)
//   score_one / score_two : binary scores (from controller)
//   point_pulse : one-cycle scoring pulse, bit0 p1, bit1 p2 (from controller)
//   winner      : 00 none, 01 p1, 10 p2, 11 tie (from controller)
//   game_state  : current state encoding (from controller)
// Modports: slave = controller side, master = environment side.
interface match_controller_if;
  import pong_pkg::*;

  logic               endofframe;
  logic [1:0]         missed;
  logic               is_moving;
  logic               restart;
  logic [SCORE_W-1:0] score_one;
  logic [SCORE_W-1:0] score_two;
  logic [1:0]         point_pulse;
  logic [1:0]         winner;
  logic [1:0]         game_state;

  modport slave (
    input  endofframe, missed, is_moving,
    output restart, score_one, score_two, point_pulse, winner, game_state
  );

  modport master (
    output endofframe, missed, is_moving,
    input  restart, score_one, score_two, point_pulse, winner, game_state
  );

endinterface

// File: rtl/frame_timer.sv
// frame_timer: loadable down-counter that steps once per frame tick and
// stops at zero.
//   clk50M, reset : clock, async active-high reset (count -> 0)
//   load          : load count with load_value (wins over tick)
//   load_value    : reload value
//   tick          : decrement enable (endofframe)
//   count         : current count
//   done          : count is zero
module frame_timer
  import pong_pkg::*;
(
  input  logic               clk50M,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  input  logic               tick,
  output logic [TIMER_W-1:0] count,
  output logic               done
);

  always_ff @(posedge clk50M or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (tick && (count != '0)) begin
      count <= count - TIMER_W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/match_controller.sv
// match_controller: pong match sequencing (idle, serve delay, rally, game
// over), scoring and winner detection.
//   clk50M : system clock, all state changes on its rising edge
//   reset  : asynchronous active-high reset
//   bus    : match_controller_if.slave (frame pulse, misses, joystick in;
//            restart, scores, point pulse, winner, state out)
// Parameters: WIN_SCORE (1..15) points to win, SERVE_FRAMES (1..255) frames
// held before a serve and after game over.
// Build option: define MATCH_AUTO_SERVE_EN to serve as soon as the serve
// delay expires, without waiting for joystick movement.
module match_controller
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_FRAMES = 120
) (
  input  logic clk50M,
  input  logic reset,
  match_controller_if.slave bus
);

  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
  localparam logic [TIMER_W-1:0] SERVE_VAL = TIMER_W'(SERVE_FRAMES);

`ifdef MATCH_AUTO_SERVE_EN
  localparam logic AUTO_SERVE = 1'b1;
`else
  localparam logic AUTO_SERVE = 1'b0;
`endif

  state_t             state, state_n;
  logic [SCORE_W-1:0] score_one, score_two, score_one_n, score_two_n;
  logic [1:0]         winner, winner_n;
  logic [1:0]         point_pulse, point_pulse_n;
  logic               tmr_load;
  logic               tmr_done;
  logic [TIMER_W-1:0] tmr_count;

  // The controller only needs done; count is exposed for observers.
  logic unused_tmr_count;
  assign unused_tmr_count = ^tmr_count;

  frame_timer u_frame_timer (
    .clk50M     (clk50M),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (SERVE_VAL),
    .tick       (bus.endofframe),
    .count      (tmr_count),
    .done       (tmr_done)
  );

  // State and score registers.
  always_ff @(posedge clk50M or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      score_one   <= '0;
      score_two   <= '0;
      winner      <= WIN_NONE;
      point_pulse <= 2'b00;
    end else begin
      state       <= state_n;
      score_one   <= score_one_n;
      score_two   <= score_two_n;
      winner      <= winner_n;
      point_pulse <= point_pulse_n;
    end
  end

  // Next-state, scoring and timer-load decode.
  always_comb begin
    state_n       = state;
    score_one_n   = score_one;
    score_two_n   = score_two;
    winner_n      = winner;
    point_pulse_n = 2'b00;
    tmr_load      = 1'b0;

    case (state)
      IDLE: begin
        if (bus.is_moving) begin
          score_one_n = '0;
          score_two_n = '0;
          winner_n    = WIN_NONE;
          tmr_load    = 1'b1;
          state_n     = SERVE;
        end
      end
      SERVE: begin
        if (tmr_done && (bus.is_moving || AUTO_SERVE)) begin
          state_n = PLAY;
        end
      end
      PLAY: begin
        // Left wall (bit0) is a point for player two, right wall for player one.
        // Leaving PLAY in the same edge keeps a held miss from counting twice.
        if (bus.endofframe && (bus.missed != 2'b00)) begin
          score_one_n   = sat_inc(score_one, bus.missed[1], WIN_VAL);
          score_two_n   = sat_inc(score_two, bus.missed[0], WIN_VAL);
          point_pulse_n = {bus.missed[0], bus.missed[1]};
          tmr_load      = 1'b1;
          if ((score_one_n == WIN_VAL) || (score_two_n == WIN_VAL)) begin
            winner_n = {score_two_n == WIN_VAL, score_one_n == WIN_VAL};
            state_n  = OVER;
          end else begin
            state_n  = SERVE;
          end
        end
      end
      OVER: begin
        if (tmr_done) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.restart     = (state != PLAY);
  assign bus.score_one   = score_one;
  assign bus.score_two   = score_two;
  assign bus.point_pulse = point_pulse;
  assign bus.winner      = winner;
  assign bus.game_state  = state;

endmodule

// File: tb/tb_match_controller.sv
// tb_match_controller: self-checking bench for match_controller with
// WIN_SCORE=3 and SERVE_FRAMES=120. Rally outcomes come from a vector table;
// expected results are queued when a miss is driven and popped when the
// point pulse appears.
module tb_match_controller;
  import pong_pkg::*;

  localparam int unsigned WIN    = 3;
  localparam int unsigned FRAMES = 120;

  logic clk50M = 1'b0;
  logic reset  = 1'b0;

  always #5 clk50M = ~clk50M;

  match_controller_if bus();

  match_controller #(.WIN_SCORE(WIN), .SERVE_FRAMES(FRAMES)) dut (
    .clk50M (clk50M),
    .reset  (reset),
    .bus    (bus)
  );

  typedef struct {
    logic       rst_first;
    logic [1:0] missed;
    logic [1:0] pp;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [1:0] st;
    logic [1:0] win;
  } vec_t;

  typedef struct {
    logic [1:0] pp;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [1:0] st;
    logic [1:0] win;
  } exp_t;

  vec_t vecs[8];
  exp_t exp_q[$];

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk50M);
    #1;
  endtask

  task automatic frame();
    bus.endofframe = 1'b1;
    tick();
    bus.endofframe = 1'b0;
    tick();
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  task automatic do_reset();
    bus.endofframe = 1'b0;
    bus.missed     = 2'b00;
    bus.is_moving  = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Drive joystick until the ball is released, bounded.
  task automatic get_to_play();
    int n;
    n = 0;
    bus.missed    = 2'b00;
    bus.is_moving = 1'b1;
    while (bus.game_state != ST_PLAY && n < 600) begin
      frame();
      n++;
    end
    check("reach_play", int'(bus.game_state), int'(ST_PLAY));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;

    vecs[0] = '{1'b0, 2'b01, 2'b10, 4'd0, 4'd1, ST_SERVE, WIN_NONE};
    vecs[1] = '{1'b0, 2'b10, 2'b01, 4'd1, 4'd1, ST_SERVE, WIN_NONE};
    vecs[2] = '{1'b0, 2'b10, 2'b01, 4'd2, 4'd1, ST_SERVE, WIN_NONE};
    vecs[3] = '{1'b0, 2'b01, 2'b10, 4'd2, 4'd2, ST_SERVE, WIN_NONE};
    vecs[4] = '{1'b0, 2'b11, 2'b11, 4'd3, 4'd3, ST_OVER,  WIN_TIE};
    vecs[5] = '{1'b1, 2'b10, 2'b01, 4'd1, 4'd0, ST_SERVE, WIN_NONE};
    vecs[6] = '{1'b0, 2'b10, 2'b01, 4'd2, 4'd0, ST_SERVE, WIN_NONE};
    vecs[7] = '{1'b0, 2'b10, 2'b01, 4'd3, 4'd0, ST_OVER,  WIN_ONE};

    bus.endofframe = 1'b0;
    bus.missed     = 2'b00;
    bus.is_moving  = 1'b0;

    // Reset state, observed before any clock edge.
    #1 reset = 1'b1;
    #1;
    check("rst_state",   int'(bus.game_state),  int'(ST_IDLE));
    check("rst_restart", int'(bus.restart),     1);
    check("rst_s1",      int'(bus.score_one),   0);
    check("rst_s2",      int'(bus.score_two),   0);
    check("rst_pp",      int'(bus.point_pulse), 0);
    check("rst_winner",  int'(bus.winner),      0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("idle_hold", int'(bus.game_state), int'(ST_IDLE));

    // First serve.
    bus.is_moving = 1'b1;
    tick();
    check("serve_state",   int'(bus.game_state), int'(ST_SERVE));
    check("serve_restart", int'(bus.restart),    1);
    check("serve_s1",      int'(bus.score_one),  0);
    check("serve_s2",      int'(bus.score_two),  0);
    frames(FRAMES - 1);
    check("serve_119", int'(bus.game_state), int'(ST_SERVE));
    frame();
    check("play_state",   int'(bus.game_state), int'(ST_PLAY));
    check("play_restart", int'(bus.restart),    0);

    // Misses without a frame pulse are ignored.
    bus.missed = 2'b01;
    repeat (3) tick();
    check("noeof_pp",    int'(bus.point_pulse), 0);
    check("noeof_state", int'(bus.game_state),  int'(ST_PLAY));
    check("noeof_s2",    int'(bus.score_two),   0);
    bus.missed = 2'b00;

    // Rally table.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].rst_first) do_reset();
      get_to_play();
      bus.missed     = vecs[i].missed;
      bus.endofframe = 1'b1;
      exp_q.push_back('{vecs[i].pp, vecs[i].s1, vecs[i].s2, vecs[i].st, vecs[i].win});
      tick();
      bus.endofframe = 1'b0;
      n = 0;
      while (bus.point_pulse == 2'b00 && n < 4) begin
        tick();
        n++;
      end
      e = exp_q.pop_front();
      check($sformatf("v%0d_pp", i),     int'(bus.point_pulse), int'(e.pp));
      check($sformatf("v%0d_s1", i),     int'(bus.score_one),   int'(e.s1));
      check($sformatf("v%0d_s2", i),     int'(bus.score_two),   int'(e.s2));
      check($sformatf("v%0d_state", i),  int'(bus.game_state),  int'(e.st));
      check($sformatf("v%0d_winner", i), int'(bus.winner),      int'(e.win));
      tick();
      check($sformatf("v%0d_pp_clear", i), int'(bus.point_pulse), 0);
      // Held miss must not count again.
      frames(5);
      check($sformatf("v%0d_hold_s1", i), int'(bus.score_one), int'(e.s1));
      check($sformatf("v%0d_hold_s2", i), int'(bus.score_two), int'(e.s2));
      bus.missed = 2'b00;

      if (e.st == ST_OVER) begin
        // Entry loaded 120; five frames already elapsed.
        bus.is_moving = 1'b0;
        frames(FRAMES - 6);
        check($sformatf("v%0d_over_hold", i), int'(bus.game_state), int'(ST_OVER));
        frame();
        check($sformatf("v%0d_idle", i),      int'(bus.game_state), int'(ST_IDLE));
        check($sformatf("v%0d_idle_s1", i),   int'(bus.score_one),  int'(e.s1));
        check($sformatf("v%0d_idle_s2", i),   int'(bus.score_two),  int'(e.s2));
        check($sformatf("v%0d_idle_win", i),  int'(bus.winner),     int'(e.win));
        bus.is_moving = 1'b1;
        tick();
        check($sformatf("v%0d_new_serve", i), int'(bus.game_state), int'(ST_SERVE));
        check($sformatf("v%0d_new_s1", i),    int'(bus.score_one),  0);
        check($sformatf("v%0d_new_win", i),   int'(bus.winner),     0);
      end
    end

    // Reset in the middle of a rally with a nonzero score.
    do_reset();
    get_to_play();
    bus.missed = 2'b10;
    frame();
    bus.missed = 2'b00;
    check("mid_s1", int'(bus.score_one), 1);
    get_to_play();
    #2 reset = 1'b1;
    #1;
    check("mid_rst_state",   int'(bus.game_state),  int'(ST_IDLE));
    check("mid_rst_restart", int'(bus.restart),     1);
    check("mid_rst_s1",      int'(bus.score_one),   0);
    check("mid_rst_pp",      int'(bus.point_pulse), 0);
    tick();
    reset = 1'b0;
    bus.is_moving = 1'b0;
    tick();
    check("post_rst_idle", int'(bus.game_state), int'(ST_IDLE));

    // Serve delay expired with no joystick movement.
    bus.is_moving = 1'b1;
    tick();
    bus.is_moving = 1'b0;
    frames(FRAMES);
    tick();
`ifdef MATCH_AUTO_SERVE_EN
    check("auto_serve", int'(bus.game_state), int'(ST_PLAY));
`else
    check("wait_serve",         int'(bus.game_state), int'(ST_SERVE));
    check("wait_serve_restart", int'(bus.restart),    1);
    bus.is_moving = 1'b1;
    tick();
    check("move_serve", int'(bus.game_state), int'(ST_PLAY));
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
